// File: rtl/eth_miim_slave.sv
// Clause-22 MDIO target: oversamples Mdc/Mdi in the Clk domain and decodes read/write frames.
// Optional `define ETH_MIIM_SLAVE_BCAST_EN lets PHYAD 5'h00 address this PHY for writes.
module eth_miim_slave #(
  parameter int PRE_LEN     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mdc,
  input  logic        Mdi,
  input  logic [4:0]  PhyAddr,
  input  logic [15:0] RdData,
  output logic        Mdo,
  output logic        MdoEn,
  output logic [4:0]  RegAddr,
  output logic [15:0] WrData,
  output logic        WrStrobe,
  output logic        RdReq,
  output logic        Busy,
  output logic        FrameErr
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST2, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_SKIP
  } state_t;

  localparam logic [5:0] PRE_MIN = 6'(PRE_LEN);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdi_sync_q, mdi_sync_d;
  logic                   mdc_prev_q, mdc_prev_d;
  logic [4:0]             pos_q, pos_d;
  logic [5:0]             pre_cnt_q, pre_cnt_d;
  logic [15:0]            sh_q, sh_d;
  logic                   rd_q, rd_d;
  logic                   mdo_q, mdo_d;
  logic                   mdoen_q, mdoen_d;
  logic [4:0]             reg_addr_q, reg_addr_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic                   rd_req_q, rd_req_d;
  logic                   frame_err_q, frame_err_d;

  logic       mdc_s, bit_in, mdc_rise, phy_ok;
  logic [4:0] addr_in;

  assign mdc_s    = mdc_sync_q[SYNC_STAGES-1];
  assign bit_in   = mdi_sync_q[SYNC_STAGES-1];
  assign mdc_rise = mdc_s & ~mdc_prev_q;
  assign addr_in  = {sh_q[3:0], bit_in};

`ifdef ETH_MIIM_SLAVE_BCAST_EN
  // Broadcast address is write-only; a read to it must never drive the pad.
  assign phy_ok = ((addr_in == PhyAddr) && !(rd_q && (addr_in == 5'd0))) ||
                  ((addr_in == 5'd0) && !rd_q);
`else
  assign phy_ok = (addr_in == PhyAddr);
`endif

  always_comb begin
    state_d     = state_q;
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], Mdc};
    mdi_sync_d  = {mdi_sync_q[SYNC_STAGES-2:0], Mdi};
    mdc_prev_d  = mdc_s;
    pos_d       = pos_q;
    pre_cnt_d   = pre_cnt_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    mdo_d       = mdo_q;
    mdoen_d     = mdoen_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    rd_req_d    = 1'b0;
    frame_err_d = 1'b0;

    if (mdc_rise) begin
      // pos_q is the bit index within the 32-bit frame that follows the preamble
      pos_d = pos_q + 5'd1;
      sh_d  = {sh_q[14:0], bit_in};
      unique case (state_q)
        S_IDLE: begin
          if (bit_in) begin
            if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if ((PRE_LEN == 0) || (pre_cnt_q >= PRE_MIN)) begin
            state_d   = S_ST2;
            pos_d     = 5'd1;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end
        S_ST2: state_d = bit_in ? S_OP : S_IDLE;
        S_OP: begin
          if (pos_q == 5'd3) begin
            unique case ({sh_q[0], bit_in})
              2'b01: begin rd_d = 1'b0; state_d = S_PHY; end
              2'b10: begin rd_d = 1'b1; state_d = S_PHY; end
              default: begin frame_err_d = 1'b1; state_d = S_SKIP; end
            endcase
          end
        end
        S_PHY: if (pos_q == 5'd8) state_d = phy_ok ? S_REG : S_SKIP;
        S_REG: begin
          if (pos_q == 5'd13) begin
            reg_addr_d = addr_in;
            rd_req_d   = rd_q;
            state_d    = S_TA;
          end
        end
        S_TA: begin
          if (pos_q == 5'd14) begin
            if (rd_q) begin
              sh_d    = RdData;
              mdoen_d = 1'b1;
              mdo_d   = 1'b0;
            end
          end else begin
            state_d = S_DATA;
            if (rd_q) begin
              mdo_d = sh_q[15];
              sh_d  = {sh_q[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          if (pos_q == 5'd31) begin
            state_d   = S_IDLE;
            pre_cnt_d = 6'd0;
            mdo_d     = 1'b0;
            mdoen_d   = 1'b0;
            if (!rd_q) begin
              wr_data_d   = {sh_q[14:0], bit_in};
              wr_strobe_d = 1'b1;
            end
          end else if (rd_q) begin
            mdo_d = sh_q[15];
            sh_d  = {sh_q[14:0], 1'b0};
          end
        end
        S_SKIP: begin
          if (pos_q == 5'd31) begin
            state_d   = S_IDLE;
            pre_cnt_d = 6'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      mdc_sync_q  <= '0;
      mdi_sync_q  <= '0;
      mdc_prev_q  <= 1'b0;
      pos_q       <= 5'd0;
      pre_cnt_q   <= 6'd0;
      sh_q        <= 16'd0;
      rd_q        <= 1'b0;
      mdo_q       <= 1'b0;
      mdoen_q     <= 1'b0;
      reg_addr_q  <= 5'd0;
      wr_data_q   <= 16'd0;
      wr_strobe_q <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdc_sync_q  <= mdc_sync_d;
      mdi_sync_q  <= mdi_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      pos_q       <= pos_d;
      pre_cnt_q   <= pre_cnt_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      mdo_q       <= mdo_d;
      mdoen_q     <= mdoen_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_req_q    <= rd_req_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Mdo      = mdo_q;
  assign MdoEn    = mdoen_q;
  assign RegAddr  = reg_addr_q;
  assign WrData   = wr_data_q;
  assign WrStrobe = wr_strobe_q;
  assign RdReq    = rd_req_q;
  assign FrameErr = frame_err_q;
  assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_miim_slave.sv
// Bench for eth_miim_slave: an MDIO master model drives frames; a register-map model predicts results.
module tb_eth_miim_slave;

`ifdef ETH_MIIM_SLAVE_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam logic [15:0] NP_RD = 16'hB00C;

  typedef struct {
    logic [4:0]  pa;
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] data;
    bit          ew;
    bit          er;
    bit          ef;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Mdc = 1'b0;
  logic        Mdi = 1'b1;
  logic [4:0]  PhyAddr = 5'h01;
  logic [15:0] RdData;
  logic        Mdo, MdoEn, WrStrobe, RdReq, Busy, FrameErr;
  logic [4:0]  RegAddr;
  logic [15:0] WrData;
  logic        Mdo_np, MdoEn_np, WrStrobe_np, RdReq_np, Busy_np, FrameErr_np;
  logic [4:0]  RegAddr_np;
  logic [15:0] WrData_np;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, en_clk = 0;
  int wr_np = 0, rd_np = 0, fe_np = 0;

  logic [15:0] host_mem [32];
  bit   [31:0] host_valid;
  logic [15:0] exp_mem [32];
  logic [4:0]  exp_regaddr = 5'd0;
  logic [15:0] exp_wrdata = 16'd0;

  always #5 Clk = ~Clk;

  eth_miim_slave #(.PRE_LEN(32), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mdc(Mdc), .Mdi(Mdi), .PhyAddr(PhyAddr), .RdData(RdData),
    .Mdo(Mdo), .MdoEn(MdoEn), .RegAddr(RegAddr), .WrData(WrData), .WrStrobe(WrStrobe),
    .RdReq(RdReq), .Busy(Busy), .FrameErr(FrameErr));

  eth_miim_slave #(.PRE_LEN(0), .SYNC_STAGES(3)) dut_np (
    .Clk(Clk), .Reset_n(Reset_n), .Mdc(Mdc), .Mdi(Mdi), .PhyAddr(5'h1F), .RdData(NP_RD),
    .Mdo(Mdo_np), .MdoEn(MdoEn_np), .RegAddr(RegAddr_np), .WrData(WrData_np),
    .WrStrobe(WrStrobe_np), .RdReq(RdReq_np), .Busy(Busy_np), .FrameErr(FrameErr_np));

  function automatic logic [15:0] init_val(input logic [4:0] a);
    return (a == 5'd2) ? 16'h796D : ({a, a, a, 1'b1} ^ 16'h3C00);
  endfunction

  // Host register file and pulse counters
  always @(posedge Clk) begin
    if (WrStrobe)    wr_cnt <= wr_cnt + 1;
    if (RdReq)       rd_cnt <= rd_cnt + 1;
    if (FrameErr)    fe_cnt <= fe_cnt + 1;
    if (MdoEn)       en_clk <= en_clk + 1;
    if (WrStrobe_np) wr_np  <= wr_np + 1;
    if (RdReq_np)    rd_np  <= rd_np + 1;
    if (FrameErr_np) fe_np  <= fe_np + 1;
    if (WrStrobe) begin
      host_mem[RegAddr]   <= WrData;
      host_valid[RegAddr] <= 1'b1;
    end
    if (RdReq) RdData <= host_valid[RegAddr] ? host_mem[RegAddr] : init_val(RegAddr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mdc_bit(input logic b, input bit use_np, output logic mo, output logic moe);
    Mdi = b;
    repeat (5) @(posedge Clk);
    #1;
    mo  = use_np ? Mdo_np : Mdo;
    moe = use_np ? MdoEn_np : MdoEn;
    Mdc = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    Mdc = 1'b0;
  endtask

  // abort_at >= 0 pulses Reset_n just before that post-preamble bit and ends the frame
  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] data, input bit use_np,
                            input int abort_at, output logic [15:0] prsd, output int enp,
                            output logic tam);
    logic [31:0] fb;
    logic mo, moe;
    fb = {2'b01, op, phy, rg, (op == 2'b10) ? 2'b11 : 2'b10, (op == 2'b10) ? 16'hFFFF : data};
    prsd = 16'd0;
    enp = 0;
    tam = 1'b1;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, use_np, mo, moe);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        chk("mdoen_before_reset", 32'(MdoEn), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("reset_mdoen", 32'(MdoEn), 32'd0);
        chk("reset_mdo", 32'(Mdo), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_regaddr", 32'(RegAddr), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        return;
      end
      mdc_bit(fb[31-i], use_np, mo, moe);
      if (moe) enp++;
      if (i == 15) tam = mo;
      if (i >= 16) prsd = {prsd[14:0], mo};
    end
    Mdi = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int w0, r0, f0, e0, enp;
    logic [15:0] prsd;
    logic tam;
    w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt; e0 = en_clk;
    PhyAddr = v.pa;
    send_frame(v.pre, v.op, v.phy, v.rg, v.data, 1'b0, -1, prsd, enp, tam);
    $display("[TB] frame %s pa=%h pre=%0d op=%b phy=%h reg=%h data=%h", tag, v.pa, v.pre, v.op,
             v.phy, v.rg, v.data);
    if (v.ew || v.er) exp_regaddr = v.rg;
    if (v.ew) begin
      exp_wrdata = v.data;
      exp_mem[v.rg] = v.data;
    end
    chk({tag, "_wrstrobe"}, 32'(wr_cnt - w0), 32'(v.ew));
    chk({tag, "_rdreq"}, 32'(rd_cnt - r0), 32'(v.er));
    chk({tag, "_frameerr"}, 32'(fe_cnt - f0), 32'(v.ef));
    chk({tag, "_regaddr"}, 32'(RegAddr), 32'(exp_regaddr));
    chk({tag, "_wrdata"}, 32'(WrData), 32'(exp_wrdata));
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_mdoen_end"}, 32'(MdoEn), 32'd0);
    if (v.er) begin
      chk({tag, "_rddata"}, 32'(prsd), 32'(exp_mem[v.rg]));
      chk({tag, "_mdoen_periods"}, 32'(enp), 32'd17);
      chk({tag, "_ta2_mdo"}, 32'(tam), 32'd0);
    end else begin
      chk({tag, "_mdoen_clks"}, 32'(en_clk - e0), 32'd0);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit bc_hit;
    r = v;
    bc_hit = BC && (v.phy == 5'd0);
    r.ew = (v.op == 2'b01) && ((v.phy == v.pa) || bc_hit);
    r.er = (v.op == 2'b10) && (v.phy == v.pa) && !bc_hit;
    r.ef = (v.op == 2'b00) || (v.op == 2'b11);
    return r;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    vec_t v;
    int w0, r0, f0, enp;
    logic [15:0] prsd;
    logic mo, moe, tam;

    for (int i = 0; i < 32; i++) exp_mem[i] = init_val(5'(i));

    //           pa     pre  op     phy    reg    data      wr  rd  fe
    tbl[0]  = '{5'h01, 32, 2'b01, 5'h01, 5'h04, 16'hA5C3, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{5'h01, 32, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5'h01, 32, 2'b11, 5'h01, 5'h05, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{5'h01, 32, 2'b01, 5'h01, 5'h05, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{5'h03, 32, 2'b01, 5'h00, 5'h07, 16'h1357, BC,   1'b0, 1'b0};
    tbl[5]  = '{5'h03, 32, 2'b10, 5'h00, 5'h07, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{5'h01, 31, 2'b01, 5'h01, 5'h06, 16'hBEEF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{5'h01, 32, 2'b10, 5'h01, 5'h06, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{5'h01, 32, 2'b00, 5'h01, 5'h08, 16'h4444, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{5'h01, 32, 2'b01, 5'h02, 5'h01, 16'h2222, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{5'h01, 40, 2'b10, 5'h01, 5'h04, 16'h0000, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_mdo", 32'(Mdo), 32'd0);
    chk("rst_mdoen", 32'(MdoEn), 32'd0);
    chk("rst_regaddr", 32'(RegAddr), 32'd0);
    chk("rst_wrdata", 32'(WrData), 32'd0);
    chk("rst_pulses", 32'({WrStrobe, RdReq, FrameErr}), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;

    for (int i = 0; i < 11; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Second ST bit wrong: frame abandoned silently
    PhyAddr = 5'h01;
    f0 = fe_cnt;
    for (int i = 0; i < 32; i++) mdc_bit(1'b1, 1'b0, mo, moe);
    mdc_bit(1'b0, 1'b0, mo, moe);
    chk("st2_busy_mid", 32'(Busy), 32'd1);
    mdc_bit(1'b0, 1'b0, mo, moe);
    Mdi = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    $display("[TB] frame st2_err");
    chk("st2_busy_end", 32'(Busy), 32'd0);
    chk("st2_frameerr", 32'(fe_cnt - f0), 32'd0);
    run_frame("after_st2", '{5'h01, 32, 2'b01, 5'h01, 5'h09, 16'h0F0F, 1'b1, 1'b0, 1'b0});

    // Back-to-back NoPre frames to the PRE_LEN=0 instance
    w0 = wr_np; r0 = rd_np; f0 = fe_np;
    send_frame(0, 2'b01, 5'h1F, 5'h03, 16'hC0DE, 1'b1, -1, prsd, enp, tam);
    $display("[TB] frame nopre_write reg=03 data=c0de");
    chk("np_wrstrobe", 32'(wr_np - w0), 32'd1);
    chk("np_wrdata", 32'(WrData_np), 32'hC0DE);
    send_frame(0, 2'b10, 5'h1F, 5'h03, 16'h0000, 1'b1, -1, prsd, enp, tam);
    $display("[TB] frame nopre_read reg=03");
    chk("np_rdreq", 32'(rd_np - r0), 32'd1);
    chk("np_frameerr", 32'(fe_np - f0), 32'd0);
    chk("np_regaddr", 32'(RegAddr_np), 32'h03);
    chk("np_rddata", 32'(prsd), 32'(NP_RD));
    chk("np_mdoen_periods", 32'(enp), 32'd17);
    chk("np_busy", 32'(Busy_np), 32'd0);

    // Reset in the middle of read data, then a clean read
    PhyAddr = 5'h01;
    send_frame(32, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 23, prsd, enp, tam);
    $display("[TB] frame read_reset_abort reg=02");
    exp_regaddr = 5'd0;
    exp_wrdata = 16'd0;
    Mdi = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    run_frame("after_reset", '{5'h01, 32, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 1'b1, 1'b0});

    // Randomized frames checked against the register-map model
    for (int n = 0; n < 40; n++) begin
      int sel;
      v.pa = 5'($urandom_range(1, 31));
      v.pre = 32 + $urandom_range(0, 3);
      v.op = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      v.phy = (sel == 0) ? 5'd0 : (sel == 3) ? 5'($urandom_range(0, 31)) : v.pa;
      v.rg = 5'($urandom_range(0, 31));
      v.data = 16'($urandom);
      v.ew = 1'b0; v.er = 1'b0; v.ef = 1'b0;
      run_frame($sformatf("rnd%0d", n), model(v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_miim_slave.md
Name: eth_miim_slave

Overview:
- PHY-side responder for the Clause-22 MII management (MDIO) protocol; the target end of the MIIM master link.
- Oversamples Mdc/Mdi in the Clk domain and decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA.
- Writes emit a register-write strobe to a host register file; reads fetch RdData from the host and shift it out on Mdo/MdoEn.
- Used in loopback benches against the MIIM master and in PHY-emulation builds.

Parameters:
- PRE_LEN, 32, consecutive 1-bits required before ST is accepted (0..32; 0 supports masters running NoPre).
- SYNC_STAGES, 2, synchronizer depth for Mdc and Mdi (2 or 3).

Ports:
- Clk  in  1  host clock
- Reset_n  in  1  asynchronous, active-low reset
- Mdc  in  1  management clock from master (asynchronous to Clk)
- Mdi  in  1  MDIO pad input
- PhyAddr  in  5  this PHY's address
- RdData  in  16  host read data for RegAddr
- Mdo  out  1  MDIO output data
- MdoEn  out  1  MDIO output enable (pad tristated when 0)
- RegAddr  out  5  decoded register address, held until next frame's REGAD
- WrData  out  16  captured write data
- WrStrobe  out  1  one-Clk write pulse
- RdReq  out  1  one-Clk read request pulse
- Busy  out  1  frame in progress (state != IDLE)
- FrameErr  out  1  one-Clk pulse on bad opcode

Behaviour:
- Reset values: Mdo=0, MdoEn=0, RegAddr=0, WrData=0, WrStrobe=0, RdReq=0, FrameErr=0, Busy=0, FSM=IDLE, preamble count=0.
- Mdc and Mdi pass through identical SYNC_STAGES flops. MdcRise = one-Clk pulse on the synced 0->1 edge. Mdi is sampled only on MdcRise.
- Mdc high and low phases are each >=3 Clk.
- All outputs are registered and update in the Clk cycle after the MdcRise that causes them.
- IDLE:
  - Bit 1: preamble count++ (saturate at 32).
  - Bit 0 with count>=PRE_LEN: go to ST2.
  - Bit 0 with count<PRE_LEN: reset count to 0, stay in IDLE.
- ST2: expects 1 -> OP. A 0 here -> IDLE, count=0, no FrameErr.
- OP (2 bits, MSB first): 01 = write, 10 = read. 00/11 -> FrameErr pulse, then SKIP.
- PHYAD (5 bits): compare with PhyAddr at the 5th bit. Mismatch -> SKIP, no FrameErr.
- REGAD (5 bits): RegAddr updated after the 5th bit. If read, RdReq pulses in the same cycle.
- TA, read:
  - On the MdcRise of TA bit 1: RdData is latched into the shift register; MdoEn=1, Mdo=0 (slave drives TA bit 2 as 0).
  - Host must have RdData valid by this MdcRise (one full Mdc period after RdReq).
- TA, write: both TA bits are ignored.
- DATA, read: each subsequent MdcRise shifts out D15..D0. On the MdcRise following D0's slot: MdoEn=0, Mdo=0, go to IDLE with count=0.
- DATA, write: captures 16 bits MSB first. After D0: WrData updated and WrStrobe pulses together in the same cycle; go to IDLE, count=0.
- SKIP: consumes the remaining bits of the 32-bit post-preamble frame (total frame = ST2+OP2+PHY5+REG5+TA2+D16); MdoEn stays 0; then IDLE, count=0.
- MdoEn is asserted only in the read TA2/DATA window; it is never asserted in IDLE or SKIP.
- Reset_n low mid-frame: immediate return to reset values, MdoEn=0 asynchronously.
- Mdc stopped mid-frame: FSM holds; no timeout.

Optional Feature:
- Macro ETH_MIIM_SLAVE_BCAST_EN.
- Defined: PHYAD 5'h00 matches regardless of PhyAddr, for writes only. A broadcast read -> SKIP; MdoEn never asserted.
- Undefined: only an exact PhyAddr match is accepted.

Test Plan:
- PhyAddr=5'h01, PRE_LEN=32; master writes reg 5'h04 = 16'hA5C3 with full preamble -> exactly one WrStrobe, RegAddr=5'h04, WrData=16'hA5C3; MdoEn stays 0 throughout.
- Read reg 5'h02, host returns RdData=16'h796D one Clk after RdReq -> Mdo sequence TA2=0 then 0111100101101101; MdoEn high for 17 Mdc periods; master Prsd=16'h796D.
- PRE_LEN=0, back-to-back NoPre write then read, PhyAddr=5'h1F -> both decoded, WrStrobe=1 pulse, RdReq=1 pulse, no FrameErr.
- Opcode 11 frame, then valid write of 16'h0001 -> FrameErr pulse once, no strobe for first frame; second frame WrData=16'h0001.
- PHYAD 5'h00 write with PhyAddr=5'h03 -> WrStrobe only when ETH_MIIM_SLAVE_BCAST_EN defined; 5'h00 read -> MdoEn=0 always.
- Reset_n pulsed low during read DATA bit 8 -> MdoEn=0 immediately; after release, a full-preamble read completes correctly.
